// File: rtl/phy_urx_defs.sv
// Shared constants for the two-byte UART receiver phy_urx2.
//   urx_state_e   : receiver FSM state encoding (also exposed on dbg_state)
//   GAP_TO_US_DEF : default maximum inter-byte gap in microsecond ticks
//   SMP_*         : microsecond offsets (counted from the start edge) at which
//                   each bit of a byte is sampled, roughly mid-bit at 115200 baud
//   is_data_smp() : true when a counter value is one of the eight data offsets
package phy_urx_defs;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BYTE1 = 2'd1,
        S_GAP   = 2'd2,
        S_BYTE2 = 2'd3
    } urx_state_e;

    localparam logic [7:0] GAP_TO_US_DEF = 8'd100;

    localparam logic [7:0] SMP_START = 8'd4;
    localparam logic [7:0] SMP_SPARE = 8'd82;
    localparam logic [7:0] SMP_STOP  = 8'd91;
    localparam logic [7:0] SMP_DATA [8] = '{8'd13, 8'd22, 8'd30, 8'd39,
                                            8'd48, 8'd56, 8'd65, 8'd74};

    function automatic logic is_data_smp(input logic [7:0] cnt);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cnt == SMP_DATA[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/urx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value.
//   clk_sys : system clock
//   rst     : synchronous active-high reset; all flops reset to the idle level (1)
//   uart_rx : asynchronous serial input, idle high
//   rx_s    : synchronized line level
//   fall    : high for one cycle when rx_s is 0 and was 1 on the previous cycle
module urx_sync (
    input  logic clk_sys,
    input  logic rst,
    input  logic uart_rx,
    output logic rx_s,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = uart_rx;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/phy_urx2.sv
// Two-byte UART frame receiver. Each byte is start(0), 8 data bits LSB first,
// one ignored spare bit and stop(1). Bits are sampled at fixed microsecond
// offsets from the start edge, counted with the external pluse_us tick.
// The second byte must start within GAP_TO_US ticks of the first stop sample.
//   clk_sys   : system clock
//   rst       : synchronous active-high reset
//   pluse_us  : one-cycle tick per microsecond
//   uart_rx   : asynchronous serial line, idle high
//   rx_data   : last received word, {first byte, second byte}
//   rx_vld    : one-cycle pulse, rx_data just updated
//   rx_err    : one-cycle pulse, frame dropped (bad stop bit or gap timeout)
//   dbg_state : current FSM state, for observation only
//
// Handshake: rx_vld / rx_err are unqualified single-cycle strobes with no
// back-pressure; rx_data is stable from the rx_vld cycle until the next one.
module phy_urx2
    import phy_urx_defs::*;
#(
    parameter logic [7:0] GAP_TO_US = GAP_TO_US_DEF
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        pluse_us,
    input  logic        uart_rx,
    output logic [15:0] rx_data,
    output logic        rx_vld,
    output logic        rx_err,
    output urx_state_e  dbg_state
);

    logic rx_s;
    logic fall;

    urx_sync u_sync (
        .clk_sys (clk_sys),
        .rst     (rst),
        .uart_rx (uart_rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );

    urx_state_e  state_q,   state_d;
    logic [7:0]  cnt_us_q,  cnt_us_d;
    logic [7:0]  gap_q,     gap_d;
    logic [7:0]  shift_q,   shift_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_vld_q,  rx_vld_d;
    logic        rx_err_q,  rx_err_d;

    logic [7:0]  gap_inc;

    assign gap_inc = gap_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_us_d  = cnt_us_q;
        gap_d     = gap_q;
        shift_d   = shift_q;
        hi_byte_d = hi_byte_q;
        rx_data_d = rx_data_q;
        rx_vld_d  = 1'b0;
        rx_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    cnt_us_d = 8'd0;
                    state_d  = S_BYTE1;
                end
            end

            S_GAP: begin
                // A start edge wins over a timeout landing on the same cycle.
                if (fall) begin
                    cnt_us_d = 8'd0;
                    state_d  = S_BYTE2;
                end else if (pluse_us) begin
                    gap_d = gap_inc;
                    if (gap_inc == GAP_TO_US) begin
                        rx_err_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end

            S_BYTE1, S_BYTE2: begin
                if (pluse_us) begin
                    cnt_us_d = cnt_us_q + 8'd1;
                    case (cnt_us_q)
                        SMP_START: begin
                            // Line back high: the start edge was a glitch.
                            // The gap counter is left alone so a glitch in
                            // byte 2 does not extend the allowed gap.
                            if (rx_s) begin
                                state_d = (state_q == S_BYTE1) ? S_IDLE : S_GAP;
                            end
                        end
                        SMP_SPARE: begin
                            // Spare bit carries no information.
                        end
                        SMP_STOP: begin
                            if (!rx_s) begin
                                rx_err_d = 1'b1;
                                state_d  = S_IDLE;
                            end else if (state_q == S_BYTE1) begin
                                hi_byte_d = shift_q;
                                gap_d     = 8'd0;
                                state_d   = S_GAP;
                            end else begin
                                rx_data_d = {hi_byte_q, shift_q};
                                rx_vld_d  = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                        default: begin
                            // LSB arrives first, so shift in from the top.
                            if (is_data_smp(cnt_us_q)) begin
                                shift_d = {rx_s, shift_q[7:1]};
                            end
                        end
                    endcase
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_us_q  <= 8'd0;
            gap_q     <= 8'd0;
            shift_q   <= 8'd0;
            hi_byte_q <= 8'd0;
            rx_data_q <= 16'h0000;
            rx_vld_q  <= 1'b0;
            rx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_us_q  <= cnt_us_d;
            gap_q     <= gap_d;
            shift_q   <= shift_d;
            hi_byte_q <= hi_byte_d;
            rx_data_q <= rx_data_d;
            rx_vld_q  <= rx_vld_d;
            rx_err_q  <= rx_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_vld    = rx_vld_q;
    assign rx_err    = rx_err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/phy_urx2.md
PHY_URX2 -- requirements
Module: phy_urx2

Interface
REQ-001 SHALL have parameter GAP_TO_US, default 8'd100, meaning max us between byte-1 stop sample and byte-2 start edge.
REQ-002 SHALL have port clk_sys  input  1  system clock, all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port pluse_us  input  1  one-clk_sys-cycle tick, once per microsecond.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  16  last received word; first byte in [15:8], second byte in [7:0].
REQ-007 SHALL have port rx_vld  output  1  one-cycle pulse, rx_data valid.
REQ-008 SHALL have port rx_err  output  1  one-cycle pulse, frame dropped (bad stop bit or inter-byte timeout).

Function
REQ-009 Frame format SHALL be two bytes, each: start(0), 8 data bits LSB first, 1 spare bit (value ignored), stop(1); bit period about 8.68 us (115200 baud).
REQ-010 uart_rx SHALL pass a 2-flop synchronizer; a falling edge is sync=0 with previous sync=1.
REQ-011 FSM states SHALL be S_IDLE, S_BYTE1, S_GAP, S_BYTE2.
REQ-012 In S_IDLE or S_GAP, a falling edge SHALL clear bit counter cnt_us (8-bit) to 0 and enter S_BYTE1 or S_BYTE2 respectively.
REQ-013 In S_BYTE1/S_BYTE2, cnt_us SHALL increment by 1 only on cycles with pluse_us=1; line edges are ignored.
REQ-014 Sampling SHALL occur on a pluse_us cycle where cnt_us (pre-increment) equals: 4 start, 13/22/30/39/48/56/65/74 data[0..7], 82 spare, 91 stop.
REQ-015 Start sample = 1 SHALL be treated as a glitch: return to S_IDLE from S_BYTE1, or to S_GAP from S_BYTE2 with gap timer preserved; no rx_err.
REQ-016 Stop sample = 0 SHALL pulse rx_err for one cycle and enter S_IDLE; rx_data unchanged.
REQ-017 Valid stop in S_BYTE1 SHALL latch the byte as the high byte, clear gap counter, and enter S_GAP.
REQ-018 In S_GAP the gap counter SHALL increment on pluse_us; on reaching GAP_TO_US it SHALL pulse rx_err and enter S_IDLE.
REQ-019 A falling edge in S_GAP on the same cycle the gap counter reaches GAP_TO_US SHALL take precedence (enter S_BYTE2, no rx_err).
REQ-020 Valid stop in S_BYTE2 SHALL load rx_data with {high byte, low byte} and pulse rx_vld on the next clk_sys cycle; FSM enters S_IDLE the same cycle.
REQ-021 rx_vld and rx_err SHALL never be asserted in the same cycle.
REQ-022 Latency: rx_vld SHALL be asserted exactly 1 clk_sys cycle after the byte-2 stop sample cycle.
REQ-023 A new frame SHALL be accepted on the first falling edge after return to S_IDLE, with no dead time.

Reset
REQ-024 rst=1 at a clock edge SHALL set: FSM S_IDLE, cnt_us 0, gap counter 0, synchronizer flops 1, byte shift registers 0, rx_data 16'h0000, rx_vld 0, rx_err 0.
REQ-025 Reset mid-frame SHALL discard the partial frame with no rx_vld or rx_err pulse; reception resumes on the next falling edge after rst deasserts.

Structure
REQ-026 Sample offsets (4,13,...,91), FSM state encodings, and GAP_TO_US default SHALL live in shared constants file phy_urx_defs, also used by the bench.
REQ-027 The synchronizer plus falling-edge detector SHALL be sub-module urx_sync (in: clk_sys, rst, uart_rx; out: rx_s, fall).
REQ-028 Byte sampling and the FSM SHALL stay in phy_urx2; target size 120-400 RTL lines.

Verification
REQ-029 Nominal: 2-byte UART transmitter sends 16'hA55A at 115200 -> exactly one rx_vld, rx_data=16'hA55A, no rx_err.
REQ-030 Back-to-back: 16'h1234 then 16'hFFFF, second frame starting 1 us after the first stop -> two rx_vld with 16'h1234 then 16'hFFFF.
REQ-031 Glitch: uart_rx low for 2 us in S_IDLE -> no rx_vld, no rx_err; a following 16'h00FF frame is received correctly.
REQ-032 Framing: byte-1 stop forced to 0 -> one rx_err about 91 us after the start edge, no rx_vld, rx_data holds its previous value.
REQ-033 Timeout: byte 1 sent, line held high -> rx_err exactly GAP_TO_US (100) us ticks after entering S_GAP; with an edge on the timeout cycle -> no rx_err.
REQ-034 Reset: rst pulsed at cnt_us=50 of byte 2 -> no pulses, rx_data=16'h0000; the next 16'hC3A5 frame is received.
